// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the WISC-SP13 pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    IREDIR = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [4:0]  OP_HALT = 5'b00000;

  localparam int unsigned OP_HI = 15;
  localparam int unsigned OP_LO = 11;
  localparam int unsigned RS_HI = 10;
  localparam int unsigned RS_LO = 8;
  localparam int unsigned RT_HI = 7;
  localparam int unsigned RT_LO = 5;

  localparam int unsigned DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pipe_ctrl_load_use_cmp.sv
// Load-use hazard comparator: ID source registers against the EX destination.
module load_use_cmp (
  input  logic [2:0] rs,
  input  logic [2:0] rt,
  input  logic       rs_valid,
  input  logic       rt_valid,
  input  logic [2:0] rd,
  output logic       hit
);

  assign hit = (rs_valid && (rs == rd)) || (rt_valid && (rt == rd));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage write enables, flush/bubble, HALT drain.
// Optional stall counter enabled by defining PIPE_CTRL_STALL_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] fd_instr,
  input  logic        fd_rs_valid,
  input  logic        fd_rt_valid,
  input  logic [2:0]  dx_rd,
  input  logic        dx_mem_read,
  input  logic        dx_branch_taken,
  input  logic        if_imem_busy,
  input  logic        xm_dmem_busy,
  output logic        pc_write,
  output logic        fd_write,
  output logic        dx_write,
  output logic        xm_write,
  output logic        mw_write,
  output logic        fd_flush,
  output logic        dx_bubble,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] drain_q, drain_d;
  logic             lu_hit;
  logic             load_use;
  logic             is_halt;
  logic             unused_bits;

  load_use_cmp u_load_use_cmp (
    .rs       (fd_instr[RS_HI:RS_LO]),
    .rt       (fd_instr[RT_HI:RT_LO]),
    .rs_valid (fd_rs_valid),
    .rt_valid (fd_rt_valid),
    .rd       (dx_rd),
    .hit      (lu_hit)
  );

  assign load_use    = dx_mem_read && lu_hit;
  assign is_halt     = (fd_instr[OP_HI:OP_LO] == OP_HALT);
  assign unused_bits = ^fd_instr[RT_LO-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (!xm_dmem_busy) begin
      unique case (state_q)
        RUN: begin
          if (dx_branch_taken) begin
            if (if_imem_busy) state_d = IREDIR;
          end else if (!load_use && is_halt) begin
            state_d = DRAIN;
            drain_d = DRAIN_INIT;
          end
        end
        IREDIR: begin
          if (!if_imem_busy) state_d = RUN;
        end
        DRAIN: begin
          drain_d = (drain_q == '0) ? '0 : drain_q - 1'b1;
          if (drain_q <= CNT_W'(1)) state_d = HALTED;
        end
        HALTED: state_d = HALTED;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    pc_write  = 1'b1;
    fd_write  = 1'b1;
    dx_write  = 1'b1;
    xm_write  = 1'b1;
    mw_write  = 1'b1;
    fd_flush  = 1'b0;
    dx_bubble = 1'b0;
    halted    = (state_q == HALTED);
    // Reset forces every enable low while rst_n is held, not just the state.
    if (!rst_n || (state_q == HALTED) || xm_dmem_busy) begin
      pc_write = 1'b0;
      fd_write = 1'b0;
      dx_write = 1'b0;
      xm_write = 1'b0;
      mw_write = 1'b0;
      if (!rst_n) halted = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (dx_branch_taken) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
          end else if (load_use) begin
            pc_write  = 1'b0;
            fd_write  = 1'b0;
            dx_bubble = 1'b1;
          end else if (is_halt || if_imem_busy) begin
            pc_write = 1'b0;
            fd_flush = 1'b1;
          end
        end
        IREDIR, DRAIN: begin
          pc_write = 1'b0;
          fd_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [15:0] stall_q;

  // A data-memory freeze holds the counter along with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (((state_q == RUN) || (state_q == IREDIR)) && !pc_write &&
                 !xm_dmem_busy && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage WISC-SP13 core. It owns every stage-register write enable and flush/bubble control. It arbitrates five conditions by fixed priority: data-memory busy freeze, taken-branch redirect, load-use stall, HALT drain, and instruction-memory busy. It holds the small state needed across cycles: pending redirect during an in-flight fetch, and the post-HALT drain. It sits beside the datapath and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
- DRAIN_CYCLES, 3: unfrozen cycles from HALT leaving ID until `halted` asserts.
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- fd_instr  in  16  instruction in IF/ID; rs=[10:8], rt=[7:5], opcode=[15:11]
- fd_rs_valid, fd_rt_valid  in  1 each  ID instruction actually reads rs / rt
- dx_rd  in  3  destination register of instruction in EX
- dx_mem_read  in  1  EX instruction is a load
- dx_branch_taken  in  1  EX resolved a taken branch/jump; target presented to PC mux
- if_imem_busy  in  1  instruction memory has not completed current fetch
- xm_dmem_busy  in  1  data memory has not completed MEM-stage access
- pc_write, fd_write, dx_write, xm_write, mw_write  out  1 each  stage register load enables
- fd_flush  out  1  IF/ID loads NOP
- dx_bubble  out  1  ID/EX loads NOP
- halted  out  1  core stopped
- stall_cycles  out  16  stall counter (see Configuration)

## Operation
- States: RUN, IREDIR, DRAIN, HALTED.
- Default, when no rule fires: all *_write=1, fd_flush=0, dx_bubble=0.
- RUN rules, first match wins:
  1. xm_dmem_busy=1: freeze. All *_write=0, no flush or bubble. State and counters hold.
  2. dx_branch_taken=1: pc_write=1, fd_flush=1, dx_bubble=1. If if_imem_busy=1 in the same cycle, go to IREDIR.
  3. Load-use: dx_mem_read=1 and (fd_rs_valid and dx_rd==rs, or fd_rt_valid and dx_rd==rt). pc_write=0, fd_write=0, dx_bubble=1.
  4. HALT in ID (opcode 5'b00000): pc_write=0, fd_flush=1. Go to DRAIN with drain count=DRAIN_CYCLES. Any in-flight fetch result is discarded.
  5. if_imem_busy=1: pc_write=0, fd_flush=1. Downstream stages advance.
- IREDIR:
  - Rule 1 still freezes.
  - Otherwise pc_write=0 and fd_flush=1 every cycle.
  - Return to RUN in the first cycle with if_imem_busy=0. The wrong-path fetch is dropped, and the PC already holds the target.
- DRAIN:
  - Rule 1 still freezes, and the count holds.
  - Otherwise pc_write=0, fd_flush=1, and the count decrements.
  - When the count reaches 0, go to HALTED.
- HALTED: all *_write=0, halted=1. Terminal until reset.
- Branch in EX beats HALT or load-use in ID, because the ID instruction is squashed.

## Timing
- Rules 1–5 are combinational from inputs and current state, with zero latency.
- State and drain count update on the rising edge of clk.
- Load-use stall lasts exactly 1 cycle. Next cycle dx_mem_read=0, because a bubble now occupies EX.
- Branch penalty: 2 squashed instructions (IF/ID and ID/EX), plus the remaining busy cycles if in IREDIR.
- HALT in ID at cycle N, no freezes: halted=1 from cycle N+1+DRAIN_CYCLES (N+4 by default).
- Reset (rst_n=0, any time including mid-IREDIR or mid-DRAIN):
  - state=RUN, drain count=0, stall_cycles=0.
  - All *_write=0, fd_flush=0, dx_bubble=0, halted=0, held for as long as rst_n is low.
- First cycle after reset release: RUN rules apply.

## Configuration
- PIPE_CTRL_STALL_CNT_EN defined:
  - stall_cycles increments on every cycle with rst_n=1, state RUN or IREDIR, and pc_write=0.
  - Saturates at 16'hFFFF.
- Undefined: stall_cycles tied to 16'h0000 and no counter flops are built. The port always exists.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - State enum (RUN, IREDIR, DRAIN, HALTED).
  - OP_HALT=5'b00000.
  - Register field positions RS_HI/LO and RT_HI/LO.
  - DRAIN_CYCLES default.
- One sub-module, load_use_cmp: combinational rs/rt-vs-dx_rd match with valid gating, producing a single hit bit.

## Test plan
- Load-use: EX=load with dx_rd=3; ID instruction with rs=3, fd_rs_valid=1 -> one cycle of pc_write=0, fd_write=0, dx_bubble=1, then normal. Repeat with rs=3 and fd_rs_valid=0 -> no stall.
- Branch plus load-use together: dx_branch_taken=1, dx_mem_read=1, matching rt -> pc_write=1, fd_flush=1, dx_bubble=1, fd_write=1.
- Redirect during fetch: dx_branch_taken=1 with if_imem_busy high for 3 cycles -> IREDIR. pc_write=0 and fd_flush=1 for 3 cycles, RUN on the cycle busy drops.
- Freeze: xm_dmem_busy=1 for 4 cycles during DRAIN -> all *_write=0. halted is delayed 4 cycles, to cycle N+8.
- HALT: HALT in ID at cycle 10, no busy -> halted=1 at cycle 14 and all *_write=0 thereafter. Reset at cycle 20 -> RUN, halted=0.
- Counter (macro on): 5 load-use stalls plus 7 imem-busy cycles -> stall_cycles=12. Preload near 16'hFFFF -> saturates. Macro off -> reads 0.
